// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      WAIT    = 2'd2,
      DISCARD = 2'd3
   } fetchState_t;

   localparam int          WORD_BYTES    = 4;
   localparam int          ENTRY_W       = 64;
   localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetchEntry_t;

   function automatic logic [31:0] alignPc(input logic [31:0] addr);
      return addr & PC_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO of {PC, instruction} entries with flush
module fetch_fifo import fetch_pkg::*; #(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic [ENTRY_W-1:0] pushData,
   input  logic               pop,
   input  logic               flush,
   output logic [ENTRY_W-1:0] headData,
   output logic [CNT_W-1:0]   count
);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wrPtr;
   logic [PTR_W-1:0]   rdPtr;
   logic               doPush;
   logic               doPop;

   // Flush dominates so a redirect never lets a stale entry in or out.
   assign doPush = push & (count != CNT_W'(DEPTH)) & ~flush;
   assign doPop  = pop & (count != '0) & ~flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) begin
            mem[wrPtr] <= pushData;
            wrPtr      <= wrPtr + 1'b1;
         end
         if (doPop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign headData = mem[rdPtr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, fetch FSM and prefetch buffer ahead of decode
// Optional watchdog enabled by defining FETCH_TIMEOUT_EN.
module instruction_fetch_unit import fetch_pkg::*; #(
   parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
   parameter int          FIFO_DEPTH     = 4,
   parameter int          TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        FetchEnable,
   output logic [31:0] PCAddressBus,
   output logic        NewInstruction,
   input  logic [31:0] InstructionBus,
   input  logic        ValidMemoryData,
   input  logic        Redirect,
   input  logic [31:0] RedirectTarget,
   output logic [31:0] InstrOut,
   output logic [31:0] InstrPC,
   output logic        InstrValid,
   input  logic        InstrReady,
   output logic        FetchFault
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   fetchState_t      state;
   fetchState_t      stateNext;
   logic [31:0]      pc;
   logic [31:0]      pcNext;
   logic             pushEn;
   logic             popEn;
   logic             issueOk;
   logic             timeoutHit;
   logic             faultBlock;
   logic [CNT_W-1:0] fifoCount;
   fetchEntry_t      pushEntry;
   fetchEntry_t      headEntry;

`ifdef FETCH_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] toCount;
   logic            fault;
   logic            waiting;

   assign waiting    = (state == WAIT) || (state == DISCARD);
   assign timeoutHit = waiting & ~ValidMemoryData & (toCount == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         toCount <= '0;
         fault   <= 1'b0;
      end else begin
         if (waiting && !ValidMemoryData && !timeoutHit) begin
            toCount <= toCount + 1'b1;
         end else begin
            toCount <= '0;
         end
         if (timeoutHit && !Redirect) begin
            fault <= 1'b1;
         end
      end
   end

   assign FetchFault = fault;
   assign faultBlock = fault;
`else
   logic unusedTimeout;
   assign unusedTimeout = (TIMEOUT_CYCLES != 0);
   assign timeoutHit    = 1'b0;
   assign FetchFault    = 1'b0;
   assign faultBlock    = 1'b0;
`endif

   assign issueOk = FetchEnable & (fifoCount < CNT_W'(FIFO_DEPTH)) & ~Redirect & ~faultBlock;

   always_comb begin
      stateNext = state;
      pcNext    = pc;
      pushEn    = 1'b0;
      case (state)
         IDLE: if (issueOk) stateNext = REQ;
         REQ:  stateNext = WAIT;
         WAIT: begin
            if (ValidMemoryData) begin
               pushEn    = 1'b1;
               pcNext    = pc + 32'(WORD_BYTES);
               stateNext = IDLE;
            end else if (timeoutHit) begin
               stateNext = IDLE;
            end
         end
         DISCARD: if (ValidMemoryData || timeoutHit) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase

      // A request pulsed in REQ is still owed a response, so it must be drained.
      if (Redirect) begin
         pushEn = 1'b0;
         pcNext = alignPc(RedirectTarget);
         case (state)
            IDLE:    stateNext = IDLE;
            REQ:     stateNext = DISCARD;
            default: stateNext = ValidMemoryData ? IDLE : DISCARD;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         pc    <= RESET_VECTOR;
      end else begin
         state <= stateNext;
         pc    <= pcNext;
      end
   end

   assign NewInstruction = (state == REQ);
   assign PCAddressBus   = pc;

   assign pushEntry = '{pc: pc, instr: InstructionBus};
   assign popEn     = InstrValid & InstrReady & ~Redirect;

   fetch_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) uFifo (
      .clk     (clk),
      .rst     (rst),
      .push    (pushEn),
      .pushData(pushEntry),
      .pop     (popEn),
      .flush   (Redirect),
      .headData(headEntry),
      .count   (fifoCount)
   );

   assign InstrValid = (fifoCount != '0);
   assign InstrOut   = headEntry.instr;
   assign InstrPC    = headEntry.pc;

endmodule
